sb_tx_arbiter: RTL and testbench

- Shares the single sideband serializer between up to NUM_REQ message sources: link-training FSM, register-access engine, retrain/error reporting.
- Runs in the clk_100MHz domain and arbitrates round-robin.
- Latches the winning 64-bit message and handshakes it into the serializer.
- Enforces a minimum idle gap between messages and reports per-requester completion or timeout.

---
 rtl/sb_tx_arbiter_if.sv | 36 +++
 rtl/sb_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_sb_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_tx_arbiter_if.sv
// ============================================================================
// sb_tx_arbiter_if : requester/serializer bundle for the sideband TX arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface sb_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_OW = $clog2(NUM_REQ);

    logic                   enable_i;
    logic [NUM_REQ-1:0]     req_i;
    logic [64*NUM_REQ-1:0]  msg_i;
    logic [NUM_REQ-1:0]     gnt_o;
    logic [NUM_REQ-1:0]     done_o;
    logic                   timeout_o;
    logic [c_OW-1:0]        owner_o;
    logic                   busy_o;
    logic [63:0]            tx_data_o;
    logic                   tx_valid_o;
    logic                   tx_ready_i;
    logic                   tx_done_i;

    modport slave (
        input  enable_i, req_i, msg_i, tx_ready_i, tx_done_i,
        output gnt_o, done_o, timeout_o, owner_o, busy_o, tx_data_o, tx_valid_o
    );

    modport master (
        output enable_i, req_i, msg_i, tx_ready_i, tx_done_i,
        input  gnt_o, done_o, timeout_o, owner_o, busy_o, tx_data_o, tx_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/sb_tx_arbiter.sv
// ============================================================================
// sb_tx_arbiter : round-robin arbiter sharing one sideband serializer
// Rev 1.0
// ============================================================================
`default_nettype none

module sb_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic       clk_100MHz,
    input  wire logic       reset,
    sb_tx_arbiter_if.slave  bus
);
    localparam int c_OW = $clog2(NUM_REQ);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES);
    localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_OW-1:0]    c_OWNER_RST = c_OW'(NUM_REQ - 1);
    localparam logic [c_TW-1:0]    c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_GW-1:0]    c_GAP_LOAD  = c_GW'(GAP_CYCLES);
    localparam logic [c_GW-1:0]    c_GAP_ONE   = c_GW'(1);
    localparam logic [NUM_REQ-1:0] c_REQ_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [c_OW-1:0]    owner_q, owner_d;
    logic [63:0]        data_q, data_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [c_TW-1:0]    tcnt_q, tcnt_d;
    logic [c_GW-1:0]    gcnt_q, gcnt_d;

    logic [63:0]        w_msgs [NUM_REQ];
    logic               w_found;
    logic [c_OW-1:0]    w_winner;
    logic               w_end;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_msg
        assign w_msgs[k] = bus.msg_i[64*k +: 64];
    end

    // Round-robin: first requester at or after owner+1, wrapping.
    always_comb begin : p_select
        logic [c_OW-1:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = owner_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = c_OW'((int'(owner_q) + i) % NUM_REQ);
            if (!w_found && bus.req_i[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin : p_next
        state_d   = state_q;
        owner_d   = owner_q;
        data_d    = data_q;
        gnt_d     = '0;
        done_d    = '0;
        timeout_d = 1'b0;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;
        w_end     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable_i && w_found) begin
                    state_d = SEND;
                    owner_d = w_winner;
                    data_d  = w_msgs[w_winner];
                    gnt_d   = c_REQ_ONE << w_winner;
                    tcnt_d  = '0;
                end
            end
            SEND: begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == c_TO_LAST) begin
                    timeout_d = 1'b1;
                    w_end     = 1'b1;
                end else if (bus.tx_ready_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tcnt_d = tcnt_q + 1'b1;
                // A completion arriving on the expiry cycle beats the timeout.
                if (bus.tx_done_i) begin
                    done_d = c_REQ_ONE << owner_q;
                    w_end  = 1'b1;
                end else if (tcnt_q == c_TO_LAST) begin
                    timeout_d = 1'b1;
                    w_end     = 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q <= c_GAP_ONE) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_end) begin
            if (GAP_CYCLES == 0) begin
                state_d = IDLE;
            end else begin
                state_d = GAP;
                gcnt_d  = c_GAP_LOAD;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= c_OWNER_RST;
            data_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            data_q    <= data_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.done_o     = done_q;
    assign bus.timeout_o  = timeout_q;
    assign bus.owner_o    = owner_q;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.tx_data_o  = data_q;
    assign bus.tx_valid_o = (state_q == SEND);

endmodule

`default_nettype wire

// File: tb/tb_sb_tx_arbiter.sv
// ============================================================================
// tb_sb_tx_arbiter : directed vectors, corner sequences and randomized model check
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sb_tx_arbiter;
    localparam int N     = 4;
    localparam int GAP_A = 4;
    localparam int TO_A  = 16;
    localparam logic [63:0] C_MSG = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sb_tx_arbiter_if #(.NUM_REQ(N)) ifa ();
    sb_tx_arbiter_if #(.NUM_REQ(N)) ifb ();

    sb_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A)) dut_a (
        .clk_100MHz (clk),
        .reset      (rst),
        .bus        (ifa.slave)
    );

    sb_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO_A)) dut_b (
        .clk_100MHz (clk),
        .reset      (rst),
        .bus        (ifb.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.enable_i = 1'b1; ifa.req_i = '0; ifa.msg_i = '0; ifa.tx_ready_i = 1'b0; ifa.tx_done_i = 1'b0;
        ifb.enable_i = 1'b1; ifb.req_i = '0; ifb.msg_i = '0; ifb.tx_ready_i = 1'b0; ifb.tx_done_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: tracks one in-flight message by its age,
    // whether it has been accepted, and how many gap cycles remain.
    // ------------------------------------------------------------------
    bit         m_inflight, m_acc;
    int         m_age, m_gap;
    logic [1:0] m_owner;
    logic [63:0] m_data;
    logic [3:0] m_gnt, m_done;
    logic       m_to;

    task automatic m_update(input logic r, input logic en, input logic [3:0] req,
                            input logic [255:0] msg, input logic rdy, input logic dn);
        m_gnt = '0; m_done = '0; m_to = 1'b0;
        if (r) begin
            m_inflight = 0; m_acc = 0; m_age = 0; m_gap = 0;
            m_owner = 2'(N - 1); m_data = '0;
        end else if (m_inflight) begin
            if (m_acc && dn) begin
                m_done = 4'b0001 << m_owner;
                m_inflight = 0; m_gap = GAP_A;
            end else if (m_age == TO_A - 1) begin
                m_to = 1'b1;
                m_inflight = 0; m_gap = GAP_A;
            end else begin
                if (!m_acc && rdy) m_acc = 1;
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (en && req != 0) begin
            for (int j = 1; j <= N; j++) begin
                int w;
                w = (int'(m_owner) + j) % N;
                if (!m_inflight && req[w]) begin
                    m_inflight = 1; m_acc = 0; m_age = 0;
                    m_owner = 2'(w);
                    m_data = msg[64*w +: 64];
                    m_gnt = 4'b0001 << w;
                end
            end
        end
    endtask

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       rdy;
        logic       dn;
        logic [3:0] e_gnt;
        logic [3:0] e_done;
        logic       e_valid;
        logic       e_busy;
    } vec_t;

    vec_t tv[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst.busy",  ifa.busy_o,     1'b0);
        chk("rst.valid", ifa.tx_valid_o, 1'b0);
        chk("rst.data",  ifa.tx_data_o,  64'h0);
        chk("rst.owner", ifa.owner_o,    2'd3);
        chk("rst.pulse", {ifa.gnt_o, ifa.done_o, ifa.timeout_o}, 9'h0);

        // Single request, table driven
        tv[0]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1};
        tv[1]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        for (int i = 2; i <= 10; i++)
            tv[i] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tv[11] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b1};
        for (int i = 12; i <= 14; i++)
            tv[i] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tv[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};

        ifa.msg_i[2*64 +: 64] = C_MSG;
        for (int i = 0; i < 16; i++) begin
            ifa.enable_i = tv[i].en; ifa.req_i = tv[i].req;
            ifa.tx_ready_i = tv[i].rdy; ifa.tx_done_i = tv[i].dn;
            step();
            chk($sformatf("single[%0d].gnt", i),   ifa.gnt_o,      tv[i].e_gnt);
            chk($sformatf("single[%0d].done", i),  ifa.done_o,     tv[i].e_done);
            chk($sformatf("single[%0d].valid", i), ifa.tx_valid_o, tv[i].e_valid);
            chk($sformatf("single[%0d].busy", i),  ifa.busy_o,     tv[i].e_busy);
            chk($sformatf("single[%0d].data", i),  ifa.tx_data_o,  C_MSG);
            chk($sformatf("single[%0d].owner", i), ifa.owner_o,    2'd2);
        end

        // Round-robin fairness
        do_reset();
        begin
            int gcyc[$];
            int gidx[$];
            int back[4];
            int dcnt;
            dcnt = 0;
            for (int k = 0; k < 4; k++) back[k] = 0;
            ifa.req_i = 4'b1111; ifa.tx_ready_i = 1'b1;
            for (int c = 0; c < 80 && gidx.size() < 6; c++) begin
                step();
                ifa.tx_done_i = 1'b0;
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) ifa.tx_done_i = 1'b1;
                end
                if (ifa.tx_valid_o) dcnt = 3;
                for (int k = 0; k < 4; k++) begin
                    if (back[k] > 0) begin
                        back[k]--;
                        if (back[k] == 0) ifa.req_i[k] = 1'b1;
                    end
                    if (ifa.gnt_o[k]) begin
                        gcyc.push_back(c); gidx.push_back(k);
                        ifa.req_i[k] = 1'b0; back[k] = 2;
                    end
                end
            end
            chk("rr.count", gidx.size(), 6);
            for (int i = 0; i < gidx.size(); i++) begin
                chk($sformatf("rr.order[%0d]", i), gidx[i], i % 4);
                if (i > 0) chk($sformatf("rr.space[%0d]", i), gcyc[i] - gcyc[i-1], 9);
            end
        end

        // Backpressure
        do_reset();
        begin
            logic [63:0] bmsg;
            int acc;
            acc = 0;
            bmsg = 64'h1357_9BDF_2468_ACE0;
            ifa.msg_i[1*64 +: 64] = bmsg;
            ifa.req_i = 4'b0010;
            step();
            chk("bp.gnt", ifa.gnt_o, 4'b0010);
            ifa.req_i = '0;
            ifa.msg_i = '0;
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("bp.valid[%0d]", i), ifa.tx_valid_o, 1'b1);
                chk($sformatf("bp.data[%0d]", i),  ifa.tx_data_o,  bmsg);
                ifa.tx_ready_i = (i == 7);
                if (ifa.tx_valid_o && ifa.tx_ready_i) acc++;
                step();
            end
            ifa.tx_ready_i = 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("bp.novalid[%0d]", i), ifa.tx_valid_o, 1'b0);
                if (ifa.tx_valid_o && ifa.tx_ready_i) acc++;
                step();
            end
            chk("bp.accepts", acc, 1);
            ifa.tx_ready_i = 1'b0; ifa.tx_done_i = 1'b1;
            step();
            ifa.tx_done_i = 1'b0;
            chk("bp.done", ifa.done_o, 4'b0010);
        end

        // Timeout
        do_reset();
        begin
            int t_to, t_g, n_to;
            bit saw_done;
            logic [3:0] g2;
            t_to = -1; t_g = -1; n_to = 0; saw_done = 0; g2 = '0;
            ifa.req_i = 4'b0001; ifa.tx_ready_i = 1'b1;
            step();
            chk("to.gnt", ifa.gnt_o, 4'b0001);
            ifa.req_i = 4'b0100;
            for (int t = 1; t <= 40 && t_g < 0; t++) begin
                step();
                ifa.tx_ready_i = 1'b0;
                if (ifa.done_o != 0) saw_done = 1;
                if (ifa.timeout_o) begin n_to++; t_to = t; end
                if (ifa.gnt_o != 0) begin t_g = t; g2 = ifa.gnt_o; end
            end
            chk("to.when", t_to, 16);
            chk("to.count", n_to, 1);
            chk("to.nodone", saw_done, 1'b0);
            chk("to.next_gnt_time", t_g, 21);
            chk("to.next_gnt", g2, 4'b0100);
        end

        // Enable and reset
        do_reset();
        ifa.enable_i = 1'b0; ifa.req_i = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("en.nognt[%0d]", i), {ifa.gnt_o, ifa.busy_o}, 5'h0);
        end
        ifa.enable_i = 1'b1;
        step();
        chk("en.gnt", ifa.gnt_o, 4'b0001);
        ifa.req_i = '0; ifa.tx_ready_i = 1'b1;
        step();
        ifa.tx_ready_i = 1'b0; ifa.enable_i = 1'b0;
        repeat (2) step();
        ifa.tx_done_i = 1'b1;
        step();
        ifa.tx_done_i = 1'b0;
        chk("en.done", ifa.done_o, 4'b0001);

        do_reset();
        ifa.req_i = 4'b0100;
        step();
        ifa.req_i = '0; ifa.tx_ready_i = 1'b1;
        step();
        ifa.tx_ready_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid.busy",  ifa.busy_o,    1'b0);
        chk("rstmid.data",  ifa.tx_data_o, 64'h0);
        chk("rstmid.owner", ifa.owner_o,   2'd3);
        begin
            bit bad;
            bad = 0;
            ifa.tx_done_i = 1'b1;
            for (int i = 0; i < 20; i++) begin
                step();
                ifa.tx_done_i = 1'b0;
                if (ifa.done_o != 0 || ifa.timeout_o) bad = 1;
            end
            chk("rstmid.nopulse", bad, 1'b0);
        end

        // GAP_CYCLES = 0, back-to-back requests
        do_reset();
        ifb.msg_i[1*64 +: 64] = 64'h1111_2222_3333_4444;
        ifb.msg_i[3*64 +: 64] = 64'h5555_6666_7777_8888;
        ifb.req_i = 4'b1010;
        step();
        chk("g0.gnt1", ifb.gnt_o, 4'b0010);
        ifb.req_i = 4'b1000; ifb.tx_ready_i = 1'b1;
        step();
        ifb.tx_ready_i = 1'b0;
        repeat (2) step();
        ifb.tx_done_i = 1'b1;
        step();
        ifb.tx_done_i = 1'b0;
        chk("g0.done1", ifb.done_o, 4'b0010);
        step();
        chk("g0.gnt2", ifb.gnt_o, 4'b1000);
        chk("g0.data2", ifb.tx_data_o, 64'h5555_6666_7777_8888);

        // Randomized run against the reference
        do_reset();
        m_update(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        begin
            logic [3:0]   rq;
            logic [255:0] mg;
            logic r, en, rdy, dn;
            rq = '0; mg = '0;
            for (int c = 0; c < 4000; c++) begin
                chk($sformatf("rand[%0d]", c),
                    {ifa.gnt_o, ifa.done_o, ifa.timeout_o, ifa.owner_o, ifa.busy_o, ifa.tx_valid_o, ifa.tx_data_o},
                    {m_gnt, m_done, m_to, m_owner, (m_inflight || m_gap > 0), (m_inflight && !m_acc), m_data});
                r   = (($urandom % 400) == 0);
                en  = (($urandom % 10) != 0);
                rdy = $urandom_range(0, 1) == 1;
                dn  = (($urandom % 8) == 0);
                for (int k = 0; k < 4; k++) begin
                    if (m_gnt[k]) begin
                        rq[k] = 1'b0;
                    end else if (!rq[k]) begin
                        mg[64*k +: 64] = {$urandom, $urandom};
                        if (($urandom % 4) == 0) rq[k] = 1'b1;
                    end
                end
                rst = r; ifa.enable_i = en; ifa.req_i = rq; ifa.msg_i = mg;
                ifa.tx_ready_i = rdy; ifa.tx_done_i = dn;
                m_update(r, en, rq, mg, rdy, dn);
                step();
            end
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
